fetch_pc_reg: RTL
=================

// Module: fetch_pc_reg
// PURPOSE
//  Y-86 sequential fetch stage with architectural PC register and status FSM.
//  - Holds the PC and reads instruction bytes from an internal byte-wide instruction memory.
//  - Splits the instruction at PC into icode/ifun/rA/rB/valC/valP for decode/execute.
//  - Loads the next PC from the PC-update stage; is its upstream counterpart.
//  - Freezes the machine on halt or on an instruction or address error.
// PARAMETERS
//  PC_W       11    PC/valP width; all PC arithmetic is modulo 2**PC_W
//  MEM_BYTES  2048  instruction memory size in bytes, addresses 0..MEM_BYTES-1
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  pc_next     in   PC_W   next PC from PC-update stage
//  pc_ld       in   1      commit current instruction, load pc_next
//  im_we       in   1      instruction memory byte write enable (program load)
//  im_addr     in   PC_W   write byte address
//  im_wdata    in   8      write byte
//  pc          out  PC_W   current PC
//  icode       out  4      byte[pc][7:4]
//  ifun        out  4      byte[pc][3:0]
//  rA          out  4      byte[pc+1][7:4] if has-reg, else 4'hF
//  rB          out  4      byte[pc+1][3:0] if has-reg, else 4'hF
//  valC        out  64     constant word, little-endian; 0 if none
//  valP        out  PC_W   pc + instruction length
//  stat        out  2      0=AOK 1=HLT 2=ADR 3=INS
//  running     out  1      stat==AOK
// BEHAVIOUR
//  - Reset: pc=0, stat=AOK, running=1. Memory contents are not cleared.
//  - Decode outputs are combinational from the pc register and memory (0-cycle latency after pc changes).
//  - Lengths by icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10.
//  - Has-reg: 2,3,4,5,6,A,B.
//  - valC location: 3,4,5 use bytes pc+2..pc+9; 7,8 use bytes pc+1..pc+8.
//  - Instruction-error check, evaluated on the instruction at pc:
//    - INS: icode > B; ifun > 3 for icode 6; ifun > 6 for icode 2 or 7; ifun != 0 for any other valid icode.
//    - ADR: pc + len - 1 > MEM_BYTES-1, computed at PC_W+1 bits so it cannot wrap.
//    - ADR takes priority over INS.
//  - Out-of-range bytes read as 8'h00 and are never wrapped.
//  - FSM states RUN, HALTED, FAULT:
//    - RUN, pc_ld=1, clean instr, icode!=0 -> pc<=pc_next, stay RUN.
//    - RUN, pc_ld=1, icode==0 (clean) -> stat<=HLT, HALTED; pc unchanged.
//    - RUN, pc_ld=1, ADR/INS -> stat<=ADR/INS, FAULT; pc unchanged.
//    - RUN, pc_ld=0 -> hold.
//    - HALTED and FAULT are sticky: pc_ld is ignored; only rst leaves.
//  - pc_next is used as given, including wrap.
//  - valP wraps modulo 2**PC_W.
//  - im_we write timing:
//    - Writes take effect at the clock edge and are allowed in any state.
//    - Same-cycle write to a byte being decoded: old byte is visible this cycle, new byte from the next.
//  - rst asserted mid-run overrides pc_ld and im_we-independent state; memory writes in the same cycle still commit.
// CONFIGURATION
//  FETCH_RETIRE_CNT_EN
//   - Defined: adds out port retired[31:0].
//     - Reset value 0.
//     - +1 on every RUN-state edge where pc_ld=1 and the instruction is clean with icode!=0.
//     - Wraps at 2**32; frozen in HALTED/FAULT.
//   - Undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  - irmovq: load 30 F3 0D 00 00 00 00 00 00 00 @0, rst -> icode=3 ifun=0 rA=F rB=3 valC=13 valP=10 stat=0.
//  - Commit: pc_next=10, pc_ld=1 over 6012 @10 -> pc=10 next edge; icode=6 rA=1 rB=2 valP=12.
//  - jXX: 73 @12, valC=0x20 -> valC=32, valP=21, rA=rB=F; pc_ld with pc_next=32 -> pc=32.
//  - Halt: 00 @32, pc_ld=1 -> stat=1, running=0; pc_ld with pc_next=0 next cycle -> pc stays 32.
//  - Faults: rst, 0xC0 @0 + pc_ld -> stat=3 INS; rst, pc=2044 reached holding 30 -> stat=2 ADR.
//  - Reset recovery: rst during HALTED -> pc=0, stat=0 next edge (and retired=0 if FETCH_RETIRE_CNT_EN).

Source files
------------

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - Y-86 fetch stage: PC register, instruction memory, split and status FSM
// Optional retired-instruction counter port enabled by FETCH_RETIRE_CNT_EN.
module fetch_pc_reg #(
    parameter int PC_W      = 11,
    parameter int MEM_BYTES = 2048
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_next,
    input  logic            pc_ld,
    input  logic            im_we,
    input  logic [PC_W-1:0] im_addr,
    input  logic [7:0]      im_wdata,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      icode,
    output logic [3:0]      ifun,
    output logic [3:0]      rA,
    output logic [3:0]      rB,
    output logic [63:0]     valC,
    output logic [PC_W-1:0] valP,
    output logic [1:0]      stat,
    output logic            running
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [31:0]     retired
`endif
);
    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_FAULT} state_t;

    logic [7:0]      imem_q [MEM_BYTES];
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      stat_q, stat_d;
    logic            running_q, running_d;
    state_t          state_q, state_d;
    logic            retire;

    logic [7:0]      ib [10];
    logic [PC_W:0]   pc_ext;
    logic [3:0]      len;
    logic            has_reg, adr_err, ins_err;

    // Addresses are one bit wider than the PC so pc+k never wraps back into memory.
    function automatic logic [7:0] rd_byte(input logic [PC_W:0] a);
        if (32'(a) < 32'(MEM_BYTES))
            rd_byte = imem_q[a[AW-1:0]];
        else
            rd_byte = 8'h00;
    endfunction

    always_ff @(posedge clk) begin
        if (im_we && (32'(im_addr) < 32'(MEM_BYTES)))
            imem_q[im_addr[AW-1:0]] <= im_wdata;
    end

    assign pc_ext = {1'b0, pc_q};

    always_comb begin
        for (int k = 0; k < 10; k++)
            ib[k] = rd_byte(pc_ext + (PC_W+1)'(k));
    end

    assign icode = ib[0][7:4];
    assign ifun  = ib[0][3:0];

    always_comb begin
        len     = 4'd1;
        has_reg = 1'b0;
        valC    = 64'd0;
        ins_err = 1'b0;
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: begin
                len     = 4'd2;
                has_reg = 1'b1;
            end
            4'h3, 4'h4, 4'h5: begin
                len     = 4'd10;
                has_reg = 1'b1;
                valC    = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
            end
            4'h7, 4'h8: begin
                len  = 4'd9;
                valC = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
            end
            default: len = 4'd1;
        endcase
        case (icode)
            4'h6:       ins_err = (ifun > 4'd3);
            4'h2, 4'h7: ins_err = (ifun > 4'd6);
            4'hC, 4'hD, 4'hE, 4'hF: ins_err = 1'b1;
            default:    ins_err = (ifun != 4'd0);
        endcase
    end

    assign adr_err = ((pc_ext + (PC_W+1)'(len) - (PC_W+1)'(1)) > (PC_W+1)'(MEM_BYTES - 1));
    assign rA      = has_reg ? ib[1][7:4] : 4'hF;
    assign rB      = has_reg ? ib[1][3:0] : 4'hF;
    assign valP    = pc_q + PC_W'(len);

    always_comb begin
        pc_d      = pc_q;
        stat_d    = stat_q;
        running_d = running_q;
        state_d   = state_q;
        retire    = 1'b0;
        if (state_q == S_RUN && pc_ld) begin
            if (adr_err) begin
                stat_d    = STAT_ADR;
                state_d   = S_FAULT;
                running_d = 1'b0;
            end else if (ins_err) begin
                stat_d    = STAT_INS;
                state_d   = S_FAULT;
                running_d = 1'b0;
            end else if (icode == 4'h0) begin
                stat_d    = STAT_HLT;
                state_d   = S_HALTED;
                running_d = 1'b0;
            end else begin
                pc_d   = pc_next;
                retire = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            stat_q    <= STAT_AOK;
            running_q <= 1'b1;
            state_q   <= S_RUN;
        end else begin
            pc_q      <= pc_d;
            stat_q    <= stat_d;
            running_q <= running_d;
            state_q   <= state_d;
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (retire)
            retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            retired_q <= 32'd0;
        else
            retired_q <= retired_d;
    end

    assign retired = retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    assign pc      = pc_q;
    assign stat    = stat_q;
    assign running = running_q;
endmodule
